// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 turn controller and its datapath.
package game_2048_pkg;

  localparam int unsigned TILE_W = 12;

  // board[row][col], row 0 at the top, col 0 on the left
  typedef logic [3:0][3:0][TILE_W-1:0] board_t;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_DIR,
    ST_RUN,
    ST_COMMIT,
    ST_CHECK,
    ST_RELEASE,
    ST_OVER
  } state_t;

endpackage

// File: rtl/game_turn_controller_if.sv
// Handshake between the turn controller (master) and the game_logic datapath (slave).
interface game_turn_controller_if;
  import game_2048_pkg::*;

  logic       logic_enable;
  logic [3:0] logic_direction;
  board_t     logic_matrix;
  logic [3:0] logic_rand_pos;
  logic       logic_ready;
  board_t     logic_matrix_D;

  modport master (
    output logic_enable, logic_direction, logic_matrix, logic_rand_pos,
    input  logic_ready, logic_matrix_D
  );

  modport slave (
    input  logic_enable, logic_direction, logic_matrix, logic_rand_pos,
    output logic_ready, logic_matrix_D
  );

endinterface

// File: rtl/game_turn_controller_rand_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5), free-running; exposes the low nibble.
module rand_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] rand_pos
);

  logic [7:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  assign rand_pos = q[3:0];

endmodule

// File: rtl/game_turn_controller.sv
// 2048 turn sequencer: owns the board, runs one game_logic pass per button press, flags win/lose.
// Optional ready watchdog in RUN enabled by defining GAME_CTRL_TIMEOUT_EN.
module game_turn_controller
  import game_2048_pkg::*;
#(
  parameter int unsigned WIN_VALUE     = 2048,
  parameter int unsigned READY_TIMEOUT = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    btn_dir,
  game_turn_controller_if.master        gl,
  output board_t                        board,
  output logic [15:0]                   moves,
  output logic                          busy,
  output logic                          win,
  output logic                          lose,
  output logic                          timeout_err
);

  state_t     state_q, state_d;
  logic       en_q;
  logic [3:0] dir_q;
  logic [3:0] rand_pos;
  logic       dir_valid;
  logic       timeout_hit;
  logic       win_now, lose_now, has_zero, has_pair;
  board_t     init_board;

  rand_lfsr #(.SEED(8'hA5)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst),
    .rand_pos (rand_pos)
  );

  assign dir_valid          = btn_dir inside {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};
  assign busy               = state_q inside {ST_RUN, ST_COMMIT, ST_CHECK};
  assign gl.logic_enable    = en_q;
  assign gl.logic_direction = dir_q;
  assign gl.logic_matrix    = board;
  assign gl.logic_rand_pos  = rand_pos;

  always_comb begin
    init_board = '0;
    init_board[rand_pos[3:2]][rand_pos[1:0]] = TILE_W'(2);
  end

  always_comb begin
    win_now  = 1'b0;
    has_zero = 1'b0;
    has_pair = 1'b0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (board[r][c] == TILE_W'(WIN_VALUE)) win_now  = 1'b1;
        if (board[r][c] == '0)                 has_zero = 1'b1;
      end
    end
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 3; c++)
        if (board[r][c] == board[r][c+1]) has_pair = 1'b1;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (board[r][c] == board[r+1][c]) has_pair = 1'b1;
    lose_now = !has_zero && !has_pair;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_IDLE;
      ST_INIT:     state_d = ST_WAIT_DIR;
      ST_WAIT_DIR: if (dir_valid) state_d = ST_RUN;
      ST_RUN: begin
        if (gl.logic_ready)   state_d = ST_COMMIT;
        else if (timeout_hit) state_d = ST_RELEASE;
      end
      ST_COMMIT:   state_d = ST_CHECK;
      ST_CHECK:    state_d = (win_now || lose_now) ? ST_OVER : ST_RELEASE;
      ST_RELEASE:  if (btn_dir == '0) state_d = ST_WAIT_DIR;
      ST_OVER:     state_d = ST_OVER;
      default:     state_d = ST_IDLE;
    endcase
    if (start) state_d = ST_INIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board <= '0;
      moves <= '0;
      win   <= 1'b0;
      lose  <= 1'b0;
      en_q  <= 1'b0;
      dir_q <= '0;
    end else begin
      en_q <= (state_d == ST_RUN);
      if (start) begin
        moves <= '0;
        win   <= 1'b0;
        lose  <= 1'b0;
      end else begin
        case (state_q)
          ST_INIT:     board <= init_board;
          ST_WAIT_DIR: if (dir_valid) dir_q <= btn_dir;
          ST_COMMIT: begin
            // an unchanged result is an illegal move and does not count
            if (gl.logic_matrix_D != board) begin
              board <= gl.logic_matrix_D;
              if (moves != 16'hFFFF) moves <= moves + 16'd1;
            end
          end
          ST_CHECK: begin
            if (win_now)  win  <= 1'b1;
            if (lose_now) lose <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GAME_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(READY_TIMEOUT) + 1;

  logic [CNT_W-1:0] run_cnt;
  logic             terr_q;

  assign timeout_hit = (state_q == ST_RUN) && (run_cnt == CNT_W'(READY_TIMEOUT - 1));
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
      terr_q  <= 1'b0;
    end else begin
      run_cnt <= (state_q == ST_RUN) ? run_cnt + 1'b1 : '0;
      if (start)                              terr_q <= 1'b0;
      else if (timeout_hit && !gl.logic_ready) terr_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (READY_TIMEOUT != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_game_turn_controller.sv
// Scoreboard bench for game_turn_controller: turn results are queued at issue and checked when busy falls.
module tb_game_turn_controller;
  import game_2048_pkg::*;

  typedef int vals_t [16];
  typedef struct {
    board_t      b;
    bit          chk_b;
    logic [15:0] moves;
    logic        win, lose, terr;
    int          en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  btn = '0;
  board_t      board;
  logic [15:0] moves;
  logic        busy, win, lose, timeout_err;
  logic        r_ready = 1'b0, s_ready = 1'b0;
  board_t      r_mat = '0;

  board_t      resp_m = '0;
  int          resp_d = 1;
  int          r_cnt = 0;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0, errors = 0;
  int          turns_done = 0, run_starts = 0, exp_runs = 0;
  logic        exp_terr = 1'b0;

  game_turn_controller_if bus();
  assign bus.logic_ready    = r_ready | s_ready;
  assign bus.logic_matrix_D = r_mat;

  game_turn_controller #(.WIN_VALUE(2048), .READY_TIMEOUT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .btn_dir     (btn),
    .gl          (bus.master),
    .board       (board),
    .moves       (moves),
    .busy        (busy),
    .win         (win),
    .lose        (lose),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic board_t mkb(input vals_t v);
    board_t b;
    for (int i = 0; i < 16; i++) b[i/4][i%4] = 12'(v[i]);
    return b;
  endfunction

  // datapath stand-in: answers resp_d cycles into RUN with resp_m
  initial forever begin
    @(negedge clk);
    if (bus.logic_enable) begin
      r_cnt++;
      r_ready = (r_cnt == resp_d);
      if (r_ready) r_mat = resp_m;
    end else begin
      r_cnt   = 0;
      r_ready = 1'b0;
    end
  end

  // monitor: a turn ends when busy falls; compare against the oldest queued expectation
  initial begin
    logic busy_p, en_p;
    int   en_run;
    exp_t e;
    string nm;
    busy_p = 1'b0; en_p = 1'b0; en_run = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_p = 1'b0; en_p = 1'b0; en_run = 0;
        continue;
      end
      if (bus.logic_enable) en_run++;
      if (bus.logic_enable && !en_p) run_starts++;
      en_p = bus.logic_enable;
      if (busy_p && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_turn_end", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e.chk_b) chk({nm, "_board"}, board, e.b);
          chk({nm, "_moves"},   moves, e.moves);
          chk({nm, "_win"},     win, e.win);
          chk({nm, "_lose"},    lose, e.lose);
          chk({nm, "_terr"},    timeout_err, e.terr);
          chk({nm, "_en_cyc"},  en_run, e.en);
        end
        turns_done++;
        en_run = 0;
      end
      busy_p = busy;
    end
  end

  task automatic turn(input string nm, input logic [3:0] dir, input board_t res, input int dly,
                      input board_t eb, input logic [15:0] em, input logic ew, input logic el,
                      input int en_exp);
    exp_t e;
    int   n;
    e.b = eb; e.chk_b = 1'b1; e.moves = em; e.win = ew; e.lose = el; e.terr = exp_terr; e.en = en_exp;
    resp_m = res;
    resp_d = dly;
    exp_q.push_back(e);
    name_q.push_back(nm);
    exp_runs++;
    n = turns_done;
    @(negedge clk);
    btn = dir;
    for (int i = 0; i < 200 && turns_done == n; i++) @(negedge clk);
    chk({nm, "_completed"}, turns_done != n, 1);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_fresh(input string nm);
    int nz, sum;
    nz = 0; sum = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (board[r][c] != '0) nz++;
        sum += int'(board[r][c]);
      end
    chk({nm, "_tiles"}, nz, 1);
    chk({nm, "_sum"}, sum, 2);
    chk({nm, "_moves"}, moves, 0);
    chk({nm, "_win"}, win, 0);
    chk({nm, "_lose"}, lose, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    board_t b_init, b_a, b_b, b_c, b_d, b_e;
    exp_t   e;
    b_init = mkb('{0,0,0,0, 0,0,0,0, 0,0,2,0, 0,0,0,0});
    b_a = mkb('{2,0,0,0, 4,4,128,128, 8,0,8,0, 16,16,0,2});
    b_b = mkb('{0,0,0,2, 0,0,8,256, 0,0,0,16, 0,0,32,2});
    b_c = mkb('{0,0,0,0, 0,0,0,2, 0,0,8,256, 0,0,2048,2});
    b_d = mkb('{2,4,2,4, 4,2,4,2, 2,4,2,4, 4,2,4,2});
    b_e = mkb('{2048,4,2,4, 4,2,4,2, 2,4,2,4, 4,2,4,2});

    repeat (3) @(negedge clk);
    chk("rst_board", board, '0);
    chk("rst_moves", moves, 0);
    chk("rst_enable", bus.logic_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {win, lose, timeout_err}, 0);
    chk("rst_rand_pos", bus.logic_rand_pos, 4'h5);

    // LFSR A5 -> 4A on the start edge, so INIT places the 2 at row 2, col 2
    rst = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("init_board", board, b_init);
    chk("init_moves", moves, 0);
    chk("init_busy", busy, 0);

    turn("setup", DIR_UP, b_a, 2, b_a, 1, 0, 0, 2);
    btn = '0; repeat (2) @(negedge clk);
    turn("right", DIR_RIGHT, b_b, 5, b_b, 2, 0, 0, 5);
    btn = '0; repeat (2) @(negedge clk);

`ifdef GAME_CTRL_TIMEOUT_EN
    exp_terr = 1'b1;
    turn("timeout", DIR_DOWN, b_c, 1000, b_b, 2, 0, 0, 32);
    btn = '0; repeat (2) @(negedge clk);
`endif

    turn("illegal", DIR_LEFT, b_b, 1, b_b, 2, 0, 0, 1);
    repeat (10) @(negedge clk);
    chk("held_runs", run_starts, exp_runs);
    chk("held_busy", busy, 0);
    btn = '0; repeat (2) @(negedge clk);

    turn("win", DIR_DOWN, b_c, 3, b_c, 3, 1, 0, 3);
    repeat (10) @(negedge clk);
    chk("over_runs", run_starts, exp_runs);
    chk("over_board", board, b_c);
    chk("over_win", win, 1);
    btn = '0;

    exp_terr = 1'b0;
    do_start();
    check_fresh("restart");

    btn = 4'b0011; repeat (8) @(negedge clk);
    chk("multibit_runs", run_starts, exp_runs);
    chk("multibit_busy", busy, 0);
    btn = '0; @(negedge clk);
    s_ready = 1'b1; repeat (3) @(negedge clk);
    s_ready = 1'b0;
    chk("stray_ready_busy", busy, 0);
    chk("stray_ready_moves", moves, 0);

    turn("lose", DIR_UP, b_d, 4, b_d, 1, 0, 1, 4);
    btn = '0; repeat (2) @(negedge clk);

    do_start();
    turn("both", DIR_LEFT, b_e, 1, b_e, 1, 1, 1, 1);
    btn = '0; repeat (2) @(negedge clk);

    // abort a turn with start after 4 RUN cycles
    do_start();
    e.b = '0; e.chk_b = 1'b0; e.moves = 0; e.win = 0; e.lose = 0; e.terr = 0; e.en = 4;
    exp_q.push_back(e); name_q.push_back("abort");
    resp_d = 1000; exp_runs++;
    @(negedge clk); btn = DIR_LEFT;
    repeat (4) @(negedge clk);
    start = 1'b1; btn = '0;
    @(negedge clk); start = 1'b0;
    chk("abort_enable", bus.logic_enable, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    check_fresh("abort_init");

    // asynchronous reset in the middle of RUN
    @(negedge clk); btn = DIR_RIGHT; exp_runs++;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_enable", bus.logic_enable, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_board", board, '0);
    btn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("total_runs", run_starts, exp_runs);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
